// File: rtl/purge_reintegration_ctrl_pkg.sv
// Shared types and helpers for the purge/reintegration controller.
// Slot state encoding plus a width helper used to size the slot counters.
package purge_reintegration_ctrl_pkg;

   typedef enum logic [2:0] {
      StInit,
      StActive,
      StWait,
      StRejoin,
      StCheck,
      StRetired
   } slot_state_e;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/purge_reintegration_ctrl_slot_fsm.sv
// Per-module purge/rejoin state machine: forgives transient purges with a delayed J pulse
// and retires a module once its rejoin attempts are used up.
module purge_slot_fsm
   import purge_reintegration_ctrl_pkg::*;
#(
   parameter int unsigned HOLD_CYC  = 8,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic active_i,
   output logic rejoin_o,
   output logic retired_o,
   output logic purge_o
);

   localparam int unsigned TimerW = width_of(HOLD_CYC);
   localparam int unsigned RetryW = width_of(MAX_RETRY + 1);
   localparam logic [TimerW-1:0] HoldLast = TimerW'(HOLD_CYC - 1);
   localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);

   slot_state_e       state_q;
   logic [TimerW-1:0] timer_q;
   logic [RetryW-1:0] retry_q;
   logic              rejoin_q;
   logic              retired_q;
   logic              purge_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StInit;
         timer_q   <= '0;
         retry_q   <= '0;
         rejoin_q  <= 1'b0;
         retired_q <= 1'b0;
         purge_q   <= 1'b0;
      end else begin
         rejoin_q <= 1'b0;
         purge_q  <= 1'b0;
         unique case (state_q)
            // Initial admission pulse; does not consume a retry.
            StInit: begin
               rejoin_q <= 1'b1;
               state_q  <= StRejoin;
            end
            StActive, StCheck: begin
               if (!active_i) begin
                  purge_q <= 1'b1;
                  if (retry_q == MaxRetry) begin
                     retired_q <= 1'b1;
                     state_q   <= StRetired;
                  end else begin
                     retry_q <= retry_q + 1'b1;
                     timer_q <= HoldLast;
                     state_q <= StWait;
                  end
               end else begin
                  state_q <= StActive;
               end
            end
            StWait: begin
               if (timer_q == '0) begin
                  rejoin_q <= 1'b1;
                  state_q  <= StRejoin;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            // Switch latches J on this edge, so the outcome is sampled one cycle later.
            StRejoin:  state_q <= StCheck;
            StRetired: state_q <= StRetired;
            default:   state_q <= StInit;
         endcase
      end
   end

   assign rejoin_o  = rejoin_q;
   assign retired_o = retired_q;
   assign purge_o   = purge_q;

endmodule

// File: rtl/purge_reintegration_ctrl.sv
// Reintegration controller for a self-purging voted array: one slot FSM per module plus
// the purge event counter, active popcount and system-failure flag.
module purge_reintegration_ctrl
   import purge_reintegration_ctrl_pkg::*;
#(
   parameter int unsigned N         = 6,
   parameter int unsigned THR       = 4,
   parameter int unsigned HOLD_CYC  = 8,
   parameter int unsigned MAX_RETRY = 3,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N-1:0]             active,
   output logic [N-1:0]             rejoin,
   output logic [N-1:0]             retired,
   output logic [$clog2(N+1)-1:0]   active_cnt,
   output logic [CNT_W-1:0]         purge_cnt,
   output logic                     sys_fail
);

   localparam int unsigned AcW = $clog2(N + 1);
   localparam logic [AcW-1:0] Thr = AcW'(THR);

   logic [N-1:0]     purge_vec;
   logic [AcW-1:0]   purge_num;
   logic [AcW-1:0]   active_num;
   logic [CNT_W:0]   purge_sum;
   logic [CNT_W-1:0] purge_cnt_d;
   logic [CNT_W-1:0] purge_cnt_q;
   logic [AcW-1:0]   active_cnt_q;
   logic             sys_fail_q;

   for (genvar i = 0; i < N; i++) begin : g_slot
      purge_slot_fsm #(
         .HOLD_CYC  (HOLD_CYC),
         .MAX_RETRY (MAX_RETRY)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .active_i  (active[i]),
         .rejoin_o  (rejoin[i]),
         .retired_o (retired[i]),
         .purge_o   (purge_vec[i])
      );
   end

   always_comb begin
      purge_num  = '0;
      active_num = '0;
      for (int i = 0; i < N; i++) begin
         purge_num  = purge_num + AcW'(purge_vec[i]);
         active_num = active_num + AcW'(active[i]);
      end
   end

   // One extra bit catches the carry so the counter clamps instead of wrapping.
   assign purge_sum   = {1'b0, purge_cnt_q} + {{(CNT_W + 1 - AcW){1'b0}}, purge_num};
   assign purge_cnt_d = purge_sum[CNT_W] ? {CNT_W{1'b1}} : purge_sum[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         purge_cnt_q  <= '0;
         active_cnt_q <= '0;
         sys_fail_q   <= 1'b0;
      end else begin
         purge_cnt_q  <= purge_cnt_d;
         active_cnt_q <= active_num;
         sys_fail_q   <= (active_num < Thr);
      end
   end

   assign purge_cnt  = purge_cnt_q;
   assign active_cnt = active_cnt_q;
   assign sys_fail   = sys_fail_q;

endmodule

// File: tb/tb_purge_reintegration_ctrl.sv
// Scoreboard bench: stimulus queues expected rejoin pulses and status snapshots by cycle,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_purge_reintegration_ctrl;

   typedef struct {
      int         cyc;
      logic [5:0] mask;
   } pulse_t;

   typedef struct {
      int         cyc;
      logic [5:0] retired;
      logic [7:0] purge;
      logic [2:0] acnt;
      logic       sf;
   } stat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] active = '0;
   logic [5:0] kill = '0;
   logic [5:0] rejoin, retired;
   logic [2:0] active_cnt;
   logic [7:0] purge_cnt;
   logic       sys_fail;

   logic [5:0] active2 = '0;
   logic [5:0] kill2 = 6'h3f;
   logic [5:0] rejoin2, retired2;
   logic [2:0] active_cnt2;
   logic [3:0] purge_cnt2;
   logic       sys_fail2;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   pulse_t pulse_q[$];
   stat_t  stat_q[$];

   purge_reintegration_ctrl u_dut (
      .clk        (clk),
      .rst        (rst),
      .active     (active),
      .rejoin     (rejoin),
      .retired    (retired),
      .active_cnt (active_cnt),
      .purge_cnt  (purge_cnt),
      .sys_fail   (sys_fail)
   );

   // Narrow counter instance, all modules dead: exercises saturation.
   purge_reintegration_ctrl #(.CNT_W(4)) u_sat (
      .clk        (clk),
      .rst        (rst),
      .active     (active2),
      .rejoin     (rejoin2),
      .retired    (retired2),
      .active_cnt (active_cnt2),
      .purge_cnt  (purge_cnt2),
      .sys_fail   (sys_fail2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance to the next negedge and model the JK switches: J=rejoin sets, kill forces low.
   task automatic step();
      @(negedge clk);
      active  = rst ? '0 : ((active | rejoin) & ~kill);
      active2 = rst ? '0 : ((active2 | rejoin2) & ~kill2);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic exp_pulse(input int at, input logic [5:0] m);
      pulse_q.push_back('{cyc: at, mask: m});
   endtask

   task automatic exp_stat(input int at, input logic [5:0] r, input logic [7:0] p,
                           input logic [2:0] a, input logic s);
      stat_q.push_back('{cyc: at, retired: r, purge: p, acnt: a, sf: s});
   endtask

   // Reset for three cycles, release, and expect the INIT admission pulse.
   task automatic do_reset();
      int r;
      rst  = 1'b1;
      kill = '0;
      steps(3);
      chk("rst_rejoin", {26'b0, rejoin}, 32'd0);
      chk("rst_retired", {26'b0, retired}, 32'd0);
      chk("rst_purge_cnt", {24'b0, purge_cnt}, 32'd0);
      chk("rst_active_cnt", {29'b0, active_cnt}, 32'd0);
      chk("rst_sys_fail", {31'b0, sys_fail}, 32'd0);
      rst = 1'b0;
      r = cyc;
      exp_pulse(r + 1, 6'h3f);
      exp_stat(r + 3, 6'h00, 8'd0, 3'd6, 1'b0);
      steps(5);
   endtask

   initial begin : monitor
      pulse_t p;
      stat_t  s;
      forever begin
         @(negedge clk);
         if (rejoin !== 6'b0) begin
            if (pulse_q.size() == 0) begin
               chk("unexpected_rejoin", {26'b0, rejoin}, 32'd0);
            end else begin
               p = pulse_q.pop_front();
               chk("rejoin_cycle", cyc, p.cyc);
               chk("rejoin_mask", {26'b0, rejoin}, {26'b0, p.mask});
            end
         end
         if (stat_q.size() != 0 && stat_q[0].cyc <= cyc) begin
            s = stat_q.pop_front();
            chk("stat_cycle", cyc, s.cyc);
            chk("retired", {26'b0, retired}, {26'b0, s.retired});
            chk("purge_cnt", {24'b0, purge_cnt}, {24'b0, s.purge});
            chk("active_cnt", {29'b0, active_cnt}, {29'b0, s.acnt});
            chk("sys_fail", {31'b0, sys_fail}, {31'b0, s.sf});
         end
      end
   end

   initial begin : stimulus
      int c;

      // Reset release and INIT admission.
      do_reset();

      // Transient drop of module 2, forgiven after HOLD_CYC.
      kill = 6'b000100;
      c = cyc + 1;
      exp_stat(c + 2, 6'h00, 8'd1, 3'd5, 1'b0);
      exp_pulse(c + 9, 6'b000100);
      exp_stat(c + 13, 6'h00, 8'd1, 3'd6, 1'b0);
      steps(3);
      kill = '0;
      steps(12);

      // Modules 0 and 5 purged together: counter steps by two in one cycle.
      kill = 6'b100001;
      c = cyc + 1;
      exp_stat(c + 1, 6'h00, 8'd1, 3'd4, 1'b0);
      exp_stat(c + 2, 6'h00, 8'd3, 3'd4, 1'b0);
      exp_pulse(c + 9, 6'b100001);
      exp_stat(c + 13, 6'h00, 8'd3, 3'd6, 1'b0);
      steps(3);
      kill = '0;
      steps(12);

      // Module 4 dead for good: three rejoin attempts, then retirement.
      kill = 6'b010000;
      c = cyc + 1;
      exp_pulse(c + 9, 6'b010000);
      exp_pulse(c + 19, 6'b010000);
      exp_pulse(c + 29, 6'b010000);
      exp_stat(c + 30, 6'h00, 8'd6, 3'd5, 1'b0);
      exp_stat(c + 31, 6'b010000, 8'd6, 3'd5, 1'b0);
      exp_stat(c + 33, 6'b010000, 8'd7, 3'd5, 1'b0);
      steps(36);

      // Reset while module 2 is holding off and module 4 is retired.
      kill = 6'b010100;
      c = cyc + 1;
      steps(3);
      do_reset();

      // Retire modules 1, 3 and 5: voter drops below threshold.
      kill = 6'b101010;
      c = cyc + 1;
      exp_stat(c + 1, 6'h00, 8'd0, 3'd3, 1'b1);
      exp_pulse(c + 9, 6'b101010);
      exp_pulse(c + 19, 6'b101010);
      exp_pulse(c + 29, 6'b101010);
      exp_stat(c + 33, 6'b101010, 8'd12, 3'd3, 1'b1);
      steps(36);

      // Module 4 retry budget was cleared by reset: a transient is forgiven again.
      kill = 6'b111010;
      c = cyc + 1;
      exp_stat(c + 2, 6'b101010, 8'd13, 3'd2, 1'b1);
      exp_pulse(c + 9, 6'b010000);
      exp_stat(c + 13, 6'b101010, 8'd13, 3'd3, 1'b1);
      steps(3);
      kill = 6'b101010;
      steps(12);

      // Six modules x four purges = 24 events into a 4-bit counter.
      chk("sat_purge_cnt", {28'b0, purge_cnt2}, 32'd15);
      chk("sat_retired", {26'b0, retired2}, 32'h3f);
      chk("sat_active_cnt", {29'b0, active_cnt2}, 32'd0);
      chk("sat_sys_fail", {31'b0, sys_fail2}, 32'd1);

      steps(2);
      chk("pulses_outstanding", pulse_q.size(), 32'd0);
      chk("stats_outstanding", stat_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
